gpio_arb: RTL

//  Round-robin arbiter sharing the single gpio register port (addr/din/wr_en/dout) between NREQ requesters.

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_rr_pick.sv | 30 +++
 rtl/gpio_arb.sv | 107 ++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared gpio register map and arbiter state encodings, used by gpio and gpio_arb.
package gpio_pkg;

  localparam logic [2:0] GPIO_MODE_REG = 3'b000;
  localparam logic [2:0] GPIO_DATA_REG = 3'b001;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_ACK   = 2'd2
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// Combinational round-robin picker: first masked request at or after the pointer, wrapping.
module gpio_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic [NREQ-1:0] i_mask,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);

  logic [NREQ-1:0] eff;
  logic [IW-1:0]   sel;

  always_comb begin
    eff     = i_req & i_mask;
    sel     = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = IW'((int'(i_ptr) + k) % NREQ);
      if (!o_valid && eff[sel]) begin
        o_valid = 1'b1;
        o_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/gpio_arb.sv
// Round-robin arbiter serialising NREQ requesters onto the single gpio register port.
// Optional GPIO_ARB_LOCK_EN: a requester holding i_lock at its ack keeps exclusive grant.
module gpio_arb
  import gpio_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 3,
  parameter int DW   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rstb,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_req_wr,
  input  logic [NREQ*AW-1:0]   i_req_addr,
  input  logic [NREQ*DW-1:0]   i_req_wdata,
  input  logic [NREQ-1:0]      i_lock,
  output logic [NREQ-1:0]      o_ack,
  output logic [DW-1:0]        o_rdata,
  output logic [AW-1:0]        o_gpio_addr,
  output logic [DW-1:0]        o_gpio_din,
  output logic                 o_gpio_wr_en,
  input  logic [DW-1:0]        i_gpio_dout
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [NREQ-1:0] mask;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

`ifdef GPIO_ARB_LOCK_EN
  logic            lock_vld;
  logic [IW-1:0]   lock_idx;

  // While a lock owner exists, only its request is visible to the picker.
  always_comb begin
    mask = '1;
    if (lock_vld) mask = NREQ'(1) << lock_idx;
  end
`else
  logic unused_lock;
  assign unused_lock = ^i_lock;
  assign mask        = '1;
`endif

  gpio_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (ptr),
    .i_mask  (mask),
    .o_valid (pick_valid),
    .o_idx   (pick_idx)
  );

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state        <= ARB_IDLE;
      ptr          <= '0;
      gnt          <= '0;
      o_ack        <= '0;
      o_rdata      <= '0;
      o_gpio_addr  <= '0;
      o_gpio_din   <= '0;
      o_gpio_wr_en <= 1'b0;
`ifdef GPIO_ARB_LOCK_EN
      lock_vld     <= 1'b0;
      lock_idx     <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          o_gpio_wr_en <= 1'b0;
          if (pick_valid) begin
            gnt          <= pick_idx;
            o_gpio_addr  <= i_req_addr[int'(pick_idx)*AW +: AW];
            o_gpio_din   <= i_req_wdata[int'(pick_idx)*DW +: DW];
            o_gpio_wr_en <= i_req_wr[pick_idx];
            state        <= ARB_ISSUE;
          end
        end
        // gpio samples the write at the end of this cycle; read data is captured for writes too.
        ARB_ISSUE: begin
          o_rdata      <= i_gpio_dout;
          o_gpio_wr_en <= 1'b0;
          o_ack        <= NREQ'(1) << gnt;
          ptr          <= IW'(rr_next(int'(gnt), NREQ));
          state        <= ARB_ACK;
        end
        ARB_ACK: begin
          o_ack <= '0;
          state <= ARB_IDLE;
`ifdef GPIO_ARB_LOCK_EN
          lock_vld <= i_lock[gnt];
          lock_idx <= gnt;
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
